qpmm_issue_ctrl: RTL and testbench

Front-end controller feeding the non-stallable QPMM_d0_16_16 pipelined Montgomery multiplier (BN254, 58 stages).
- Accepts tagged operand pairs over a valid/ready interface.
- Tracks in-flight operations with a valid/tag shift line aligned to the multiplier latency.
- Captures results into an output FIFO with backpressure.
- Credit-based admission guarantees no result is ever dropped.

---
 rtl/PARAMS_BN254_16_16.sv | 28 ++
 rtl/qpmm_result_fifo.sv | 68 ++++++
 rtl/qpmm_issue_ctrl.sv | 130 +++++++++++++
 tb/tb_qpmm_issue_ctrl.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/PARAMS_BN254_16_16.sv
// Shared types and constants for the BN254 16x16-digit QPMM datapath and its
// issue controller.
package PARAMS_BN254_16_16;

  // Field elements are carried in redundant form: 17 digits of 16 bits.
  localparam int DIGIT_W  = 16;
  localparam int N_DIGITS = 17;
  localparam int FP_W     = DIGIT_W * N_DIGITS;

  typedef logic [FP_W-1:0] qpmm_fp_t;

  // BN254 base-field prime, zero-extended to the redundant width.
  localparam qpmm_fp_t Mod = {16'h0000,
    256'h30644e72e131a029b85045b68181585d97816a916871ca8d3c208c16d87cfd47};

  // Edge that loads the multiplier operands to the edge after which Z is valid.
  localparam int QPMM_LATENCY = 58;

  // Width of the user tag travelling with each operation.
  localparam int QPMM_TAG_W = 8;

  // One result FIFO entry: raw multiplier output plus the tag of its operation.
  typedef struct packed {
    qpmm_fp_t              z;
    logic [QPMM_TAG_W-1:0] tag;
  } qpmm_res_t;

endpackage

// File: rtl/qpmm_result_fifo.sv
// First-word-fall-through result FIFO. The head entry is held in its own
// register so the outputs have a defined reset value while the storage array
// stays reset-free.
module qpmm_result_fifo
  import PARAMS_BN254_16_16::*;
#(
  parameter int DEPTH = 64
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   push,
  input  qpmm_res_t              push_data,
  input  logic                   pop,
  output qpmm_res_t              head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  qpmm_res_t        mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] rd_ptr_nxt;
  logic             do_push;
  logic             do_pop;

  assign empty      = (count == '0);
  assign full       = (count == CNT_W'(DEPTH));
  assign do_pop     = pop && !empty;
  // A push into a full FIFO is only legal when the head leaves on the same edge.
  assign do_push    = push && (!full || do_pop);
  assign rd_ptr_nxt = rd_ptr + 1'b1;

  // Storage write; no reset needed because the head register masks stale data.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointers, occupancy and the fall-through head register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      head   <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr_nxt;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (do_pop) begin
        // Next head is the following stored entry, or the incoming word when
        // the popped entry was the last one.
        if (count > CNT_W'(1))  head <= mem[rd_ptr_nxt];
        else if (do_push)       head <= push_data;
      end else if (do_push && empty) begin
        head <= push_data;
      end
    end
  end

endmodule

// File: rtl/qpmm_issue_ctrl.sv
// Issue controller in front of the non-stallable pipelined Montgomery
// multiplier. Operations are admitted only while a FIFO slot is reserved for
// their result, so the multiplier output can always be captured.
//
// Handshakes: a transfer happens on an edge where valid and ready are both 1.
// Valid must not depend on ready. in_ready is a register (no path from
// in_valid or out_ready); out_valid reflects the FIFO head, and out_Z/out_tag
// stay stable while out_valid is high and out_ready is low.
module qpmm_issue_ctrl
  import PARAMS_BN254_16_16::*;
#(
  parameter int N_PIPELINE_STAGES = QPMM_LATENCY,
  parameter int FIFO_DEPTH        = 64,
  parameter int TAG_W             = QPMM_TAG_W
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             in_valid,
  output logic             in_ready,
  input  qpmm_fp_t         in_A,
  input  qpmm_fp_t         in_B,
  input  logic [TAG_W-1:0] in_tag,
  output qpmm_fp_t         mm_A,
  output qpmm_fp_t         mm_B,
  input  qpmm_fp_t         mm_Z,
  output logic             out_valid,
  input  logic             out_ready,
  output qpmm_fp_t         out_Z,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy,
  output logic             err_overflow
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic                   accept;
  logic                   pop;
  logic                   push_ok;
  logic [N_PIPELINE_STAGES-1:0] sr_valid;
  logic [TAG_W-1:0]       sr_tag [N_PIPELINE_STAGES];
  logic                   cap_valid;
  logic [TAG_W-1:0]       cap_tag;
  logic [CNT_W-1:0]       inflight;
  logic [CNT_W-1:0]       fifo_count;
  logic [CNT_W:0]         used_next;
  logic                   fifo_full;
  logic                   fifo_empty;
  qpmm_res_t              cap_data;
  qpmm_res_t              fifo_head;

  assign accept   = in_valid && in_ready;
  assign pop      = out_valid && out_ready;
  assign push_ok  = cap_valid && (!fifo_full || pop);
  assign cap_data = '{z: mm_Z, tag: cap_tag};

  // Operand registers feeding the multiplier; zeros on idle cycles.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mm_A <= '0;
      mm_B <= '0;
    end else begin
      mm_A <= accept ? in_A : '0;
      mm_B <= accept ? in_B : '0;
    end
  end

  // Valid/tag line tracking the multiplier; the capture slot after its tail
  // lines up with the cycle in which mm_Z holds that operation's result.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sr_valid  <= '0;
      for (int i = 0; i < N_PIPELINE_STAGES; i++) sr_tag[i] <= '0;
      cap_valid <= 1'b0;
      cap_tag   <= '0;
    end else begin
      sr_valid  <= {sr_valid[N_PIPELINE_STAGES-2:0], accept};
      sr_tag[0] <= accept ? in_tag : '0;
      for (int i = 1; i < N_PIPELINE_STAGES; i++) sr_tag[i] <= sr_tag[i-1];
      cap_valid <= sr_valid[N_PIPELINE_STAGES-1];
      cap_tag   <= sr_tag[N_PIPELINE_STAGES-1];
    end
  end

  // Slots committed after this edge: queued results plus operations in flight.
  // A capture moves one from in-flight to queued; a dropped capture only
  // leaves the in-flight count.
  always_comb begin
    used_next = {1'b0, fifo_count} + {1'b0, inflight};
    if (accept)                used_next = used_next + 1'b1;
    if (pop)                   used_next = used_next - 1'b1;
    if (cap_valid && !push_ok) used_next = used_next - 1'b1;
  end

  // In-flight counter, credit-derived ready and the sticky overflow flag.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      inflight     <= '0;
      in_ready     <= 1'b0;
      err_overflow <= 1'b0;
    end else begin
      case ({accept, cap_valid})
        2'b10:   inflight <= inflight + 1'b1;
        2'b01:   inflight <= inflight - 1'b1;
        default: inflight <= inflight;
      endcase
      in_ready <= (used_next < (CNT_W+1)'(FIFO_DEPTH));
      if (cap_valid && fifo_full && !pop) err_overflow <= 1'b1;
    end
  end

  qpmm_result_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rstn      (rstn),
    .push      (cap_valid),
    .push_data (cap_data),
    .pop       (pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign out_valid = !fifo_empty;
  assign out_Z     = fifo_head.z;
  assign out_tag   = fifo_head.tag;
  assign busy      = (inflight != '0) || (fifo_count != '0);

endmodule

// File: tb/tb_qpmm_issue_ctrl.sv
// Directed bench for qpmm_issue_ctrl with a behavioural fixed-latency
// multiplier stand-in and an expected-result queue.
module tb_qpmm_issue_ctrl;
  import PARAMS_BN254_16_16::*;

  localparam int LAT   = QPMM_LATENCY;
  localparam int DEPTH = 64;
  localparam int TW    = QPMM_TAG_W;
  localparam int EW    = FP_W + TW;

  logic          clk = 1'b0;
  logic          rstn;
  logic          in_valid;
  logic          in_ready;
  qpmm_fp_t      in_A;
  qpmm_fp_t      in_B;
  logic [TW-1:0] in_tag;
  qpmm_fp_t      mm_A;
  qpmm_fp_t      mm_B;
  qpmm_fp_t      mm_Z;
  logic          out_valid;
  logic          out_ready;
  qpmm_fp_t      out_Z;
  logic [TW-1:0] out_tag;
  logic          busy;
  logic          err_overflow;

  logic [EW-1:0] exp_q[$];
  int            checks   = 0;
  int            failures = 0;
  int            n_acc    = 0;
  int            n_pop    = 0;

  qpmm_fp_t      pipe [LAT];

  // Clock and reset
  always #5 clk = ~clk;

  qpmm_issue_ctrl dut (
    .clk          (clk),
    .rstn         (rstn),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_A         (in_A),
    .in_B         (in_B),
    .in_tag       (in_tag),
    .mm_A         (mm_A),
    .mm_B         (mm_B),
    .mm_Z         (mm_Z),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_Z        (out_Z),
    .out_tag      (out_tag),
    .busy         (busy),
    .err_overflow (err_overflow)
  );

  // Stand-in multiplier: operand-dependent function, exactly LAT edges deep.
  function automatic qpmm_fp_t mul_model(input qpmm_fp_t a, input qpmm_fp_t b);
    return a ^ {b[FP_W-9:0], b[FP_W-1:FP_W-8]};
  endfunction

  always @(posedge clk) begin
    pipe[0] <= mul_model(mm_A, mm_B);
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign mm_Z = pipe[LAT-1];

  function automatic qpmm_fp_t rand_fp();
    logic [287:0] r;
    for (int w = 0; w < 9; w++) r[w*32 +: 32] = $urandom;
    return r[FP_W-1:0];
  endfunction

  task automatic chk(input string name, input logic [EW-1:0] obs, input logic [EW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got %0h expected %0h", name, obs, exp);
    end
  endtask

  // One clock: record accepts into the scoreboard, compare pops, advance.
  task automatic tick();
    logic [EW-1:0] e;
    if (in_valid && in_ready) begin
      exp_q.push_back({mul_model(in_A, in_B), in_tag});
      n_acc++;
    end
    if (out_valid && out_ready) begin
      n_pop++;
      chk("result_expected", (exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("result", {out_Z, out_tag}, e);
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!out_valid && lat < 200) begin
      tick();
      lat++;
    end
  endtask

  task automatic drain(input int bound, output int pops);
    int p0;
    int c;
    p0 = n_pop;
    c  = 0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    while ((exp_q.size() != 0 || out_valid) && c < bound) begin
      tick();
      c++;
    end
    pops = n_pop - p0;
    out_ready = 1'b0;
    chk("drain_complete", (exp_q.size() == 0 && !out_valid), 1);
  endtask

  task automatic chk_reset_state(input string pfx);
    chk({pfx, "_in_ready"},     in_ready,     0);
    chk({pfx, "_mm_A"},         mm_A,         0);
    chk({pfx, "_mm_B"},         mm_B,         0);
    chk({pfx, "_out_valid"},    out_valid,    0);
    chk({pfx, "_out_Z"},        out_Z,        0);
    chk({pfx, "_out_tag"},      out_tag,      0);
    chk({pfx, "_busy"},         busy,         0);
    chk({pfx, "_err_overflow"}, err_overflow, 0);
  endtask

  task automatic single_op(input string pfx);
    int lat;
    in_valid = 1'b1;
    in_A     = 1;
    in_B     = 1;
    in_tag   = 8'h05;
    tick();
    chk({pfx, "_mm_A_loaded"}, mm_A, 1);
    in_valid = 1'b0;
    chk({pfx, "_busy_inflight"}, busy, 1);
    wait_valid(lat);
    chk({pfx, "_latency"}, lat, LAT + 1);
    chk({pfx, "_out_tag"}, out_tag, 8'h05);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({pfx, "_busy_after_pop"},  busy,      0);
    chk({pfx, "_empty_after_pop"}, out_valid, 0);
  endtask

  // Watchdog so a stuck run still reports.
  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Directed sequence
  initial begin
    int drops;
    int p0;
    int a0;
    int pops;
    int ov;
    rstn      = 1'b0;
    in_valid  = 1'b0;
    in_A      = '0;
    in_B      = '0;
    in_tag    = '0;
    out_ready = 1'b0;

    // Reset values
    @(negedge clk);
    @(negedge clk);
    chk_reset_state("rst");
    rstn = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("ready_after_release", in_ready, 1);

    // Single operation latency and tag
    single_op("single");

    // Streaming with out_ready high
    out_ready = 1'b1;
    p0    = n_pop;
    drops = 0;
    for (int i = 0; i < 1000; i++) begin
      in_valid = 1'b1;
      in_A     = rand_fp();
      in_B     = rand_fp();
      in_tag   = TW'(i);
      if (!in_ready) drops++;
      tick();
    end
    chk("stream_ready_drops", drops, 0);
    chk("stream_pops", n_pop - p0, 1000 - (LAT + 2));
    drain(200, pops);
    chk("stream_tail_pops", pops, LAT + 2);

    // Backpressure: fill every credit
    out_ready = 1'b0;
    a0 = n_acc;
    for (int i = 0; i < 130; i++) begin
      in_valid = 1'b1;
      in_A     = rand_fp();
      in_B     = rand_fp();
      in_tag   = TW'(i + 17);
      tick();
    end
    chk("bp_accepts", n_acc - a0, DEPTH);
    chk("bp_ready_low", in_ready, 0);
    chk("bp_out_valid", out_valid, 1);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("bp_credit_release", in_ready, 1);
    drain(200, pops);
    chk("bp_pops", pops + 1, DEPTH);
    chk("bp_no_overflow", err_overflow, 0);

    // 63 queued, one in flight, pop on its capture edge
    a0 = n_acc;
    for (int i = 0; i < DEPTH - 1; i++) begin
      in_valid = 1'b1;
      in_A     = rand_fp();
      in_B     = rand_fp();
      in_tag   = TW'(i * 3);
      tick();
    end
    chk("pp_accepts", n_acc - a0, DEPTH - 1);
    in_valid = 1'b0;
    for (int i = 0; i < 70; i++) tick();
    chk("pp_ready_one_credit", in_ready, 1);
    in_valid = 1'b1;
    in_A     = rand_fp();
    in_B     = rand_fp();
    in_tag   = 8'hA5;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < LAT; i++) tick();
    chk("pp_ready_low_full_credit", in_ready, 0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("pp_ready_after_pushpop", in_ready, 1);
    chk("pp_no_overflow", err_overflow, 0);
    drain(200, pops);
    chk("pp_drain_pops", pops, DEPTH - 1);

    // Reset with 30 in flight and 10 queued
    for (int i = 0; i < 40; i++) begin
      in_valid = 1'b1;
      in_A     = rand_fp();
      in_B     = rand_fp();
      in_tag   = TW'(200 + i);
      tick();
    end
    in_valid = 1'b0;
    for (int i = 0; i < 29; i++) tick();
    chk("mid_out_valid", out_valid, 1);
    rstn = 1'b0;
    exp_q.delete();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_state("mid_rst");
    rstn = 1'b1;
    out_ready = 1'b1;
    ov = 0;
    for (int i = 0; i < 100; i++) begin
      if (out_valid) ov++;
      tick();
    end
    out_ready = 1'b0;
    chk("post_rst_no_stale", ov, 0);
    single_op("fresh");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
